// File: rtl/exp_log_arbiter.sv
// Round-robin arbiter that shares one combinational exp_log LUT among NREQ requesters.
// One result register per block gives 1-cycle latency and sustains one result per cycle.
module exp_log_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [7*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [6:0]        lut_in,
  input  logic [14:0]       lut_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [14:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] idx;
  logic           found;
  logic           accept;
  logic           grant;

  assign accept = !rsp_valid || rsp_ready;

  // NREQ is a power of two, so IDW-bit addition wraps modulo NREQ.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr + IDW'(i);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Reset gates the grant so no handshake can complete while rst_n is low.
  assign grant = found && accept && rst_n;

  always_comb begin
    req_ready = '0;
    lut_in    = '0;
    if (grant) begin
      req_ready[gnt_idx] = 1'b1;
      lut_in             = req_data[7*gnt_idx +: 7];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else if (grant) begin
      ptr       <= gnt_idx + 1'b1;
      rsp_valid <= 1'b1;
      rsp_data  <= lut_out;
      rsp_id    <= gnt_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
